// File: rtl/lsu_align.sv
// Purpose : load/store alignment between the core memory stage and a word-addressed data memory.
// Latency : resp_valid 1 cycle after acceptance (2 when a word boundary is crossed).
// Backpress: req_ready is high only in IDLE; the core holds or re-presents req_* until accepted.
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   req_valid/req_ready      core request handshake
//   req_we/funct3/addr/wdata request fields (wdata right-aligned)
//   resp_valid/rdata/err     one-cycle response pulse
//   mem_a/we/wstrb/wd/rd     word-addressed memory port (mem_rd is combinational)
module lsu_align #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {S_IDLE, S_SECOND, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] buf_q, buf_d;

  // Request decode (IDLE-time, from the live request)
  logic [1:0]  o_in;
  logic [2:0]  n_in;
  logic [3:0]  m_in;
  logic [4:0]  sh_in;
  logic        crossing;
  logic        legal;

  // Second-half decode (from latched request)
  logic [1:0]  o_q;
  logic [3:0]  m_q;
  logic [2:0]  rem_q;
  logic [5:0]  sh2_q;
  logic        mem_we_raw;
  logic [31:0] ext;

  always_comb begin
    o_in  = req_addr[1:0];
    sh_in = {o_in, 3'b000};
    case (req_funct3[1:0])
      2'b00:   begin n_in = 3'd1; m_in = 4'b0001; end
      2'b01:   begin n_in = 3'd2; m_in = 4'b0011; end
      default: begin n_in = 3'd4; m_in = 4'b1111; end
    endcase
    crossing = (({1'b0, o_in} + n_in) > 3'd4);
    legal = !((req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111))
            && !(req_we && req_funct3[2])
            && !(crossing && !MISALIGN_EN);
  end

  always_comb begin
    o_q = addr_q[1:0];
    case (funct3_q[1:0])
      2'b00:   m_q = 4'b0001;
      2'b01:   m_q = 4'b0011;
      default: m_q = 4'b1111;
    endcase
    // Bytes of the access that landed in the first word; the remainder spills into the next.
    rem_q = 3'd4 - {1'b0, o_q};
    sh2_q = {rem_q, 3'b000};
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    buf_d      = buf_q;
    mem_a      = {addr_q[31:2], 2'b00};
    mem_we_raw = 1'b0;
    mem_wstrb  = 4'b0000;
    mem_wd     = 32'd0;
    case (state_q)
      S_IDLE: begin
        mem_a  = {req_addr[31:2], 2'b00};
        mem_wd = req_wdata << sh_in;
        if (req_valid) begin
          mem_we_raw = req_we && legal;
          mem_wstrb  = (req_we && legal) ? (m_in << o_in) : 4'b0000;
          addr_d     = req_addr;
          we_d       = req_we;
          funct3_d   = req_funct3;
          wdata_d    = req_wdata;
          err_d      = !legal;
          buf_d      = mem_rd >> sh_in;
          state_d    = (crossing && legal) ? S_SECOND : S_RESP;
        end
      end
      S_SECOND: begin
        // 30-bit increment wraps naturally at the top of the address space.
        mem_a      = {addr_q[31:2] + 30'd1, 2'b00};
        mem_we_raw = we_q;
        mem_wstrb  = we_q ? (m_q >> rem_q) : 4'b0000;
        mem_wd     = wdata_q >> sh2_q;
        buf_d      = buf_q | (mem_rd << sh2_q);
        state_d    = S_RESP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Extension of the assembled load buffer to the requested width.
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   ext = {{24{buf_q[7]  & ~funct3_q[2]}}, buf_q[7:0]};
      2'b01:   ext = {{16{buf_q[15] & ~funct3_q[2]}}, buf_q[15:0]};
      default: ext = buf_q;
    endcase
  end

  assign mem_we     = mem_we_raw && !reset;
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q && !we_q) ? ext : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      wdata_q  <= 32'd0;
      err_q    <= 1'b0;
      buf_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      buf_q    <= buf_d;
    end
  end

endmodule
